// File: rtl/mont_exp_ctrl_pkg.sv
// Shared constants and FSM encoding for the Montgomery exponentiation sequencer.
package mont_exp_ctrl_pkg;

  localparam int M_LENGTH   = 512;
  localparam int W          = M_LENGTH + 16;
  localparam int EXP_LENGTH = 32;
  localparam int MM_GUARD   = 2;

  localparam int IDX_W   = $clog2(EXP_LENGTH);
  localparam int GUARD_W = (MM_GUARD < 1) ? 1 : $clog2(MM_GUARD + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ_GO,
    ST_SQ_WAIT,
    ST_MUL_GO,
    ST_MUL_WAIT,
    ST_NEXT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/mont_exp_bitscan.sv
// Exponent walker: MSB-first shift register plus a down-counting bit index.
module mont_exp_bitscan
  import mont_exp_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [EXP_LENGTH-1:0] exp,
  output logic                  cur_bit,
  output logic                  last_bit
);

  logic [EXP_LENGTH-1:0] bits;
  logic [IDX_W-1:0]      idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits <= '0;
      idx  <= IDX_W'(EXP_LENGTH - 1);
    end else if (load) begin
      bits <= exp;
      idx  <= IDX_W'(EXP_LENGTH - 1);
    end else if (advance) begin
      bits <= {bits[EXP_LENGTH-2:0], 1'b0};
      idx  <= idx - IDX_W'(1);
    end
  end

  assign cur_bit  = bits[EXP_LENGTH-1];
  assign last_bit = (idx == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional build macro CONST_TIME_EN: issue the multiply for every exponent bit, keep it only when the bit is set.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          base_mont,
  input  logic [EXP_LENGTH-1:0] exp,
  input  logic [W-1:0]          one_mont,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          result,
  output logic                  mm_start,
  output logic [W-1:0]          mm_a,
  output logic [W-1:0]          mm_b,
  input  logic                  mm_done,
  input  logic [W-1:0]          mm_product
);

  state_t             state;
  logic [W-1:0]       acc;
  logic [W-1:0]       base;
  logic [GUARD_W-1:0] guard;

  logic cur_bit;
  logic last_bit;
  logic scan_load;
  logic scan_advance;

  assign scan_load    = (state == ST_IDLE) && start;
  assign scan_advance = (state == ST_NEXT) && !last_bit;

  mont_exp_bitscan u_bitscan (
    .clk      (clk),
    .reset    (reset),
    .load     (scan_load),
    .advance  (scan_advance),
    .exp      (exp),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      acc      <= '0;
      base     <= '0;
      guard    <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base  <= base_mont;
            acc   <= one_mont;
            busy  <= 1'b1;
            state <= ST_SQ_GO;
          end
        end
        ST_SQ_GO: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= acc;
          guard    <= GUARD_W'(MM_GUARD);
          state    <= ST_SQ_WAIT;
        end
        // mm_done may still be high from the previous product until the
        // multiplier has seen our start; the guard hides that stale level.
        ST_SQ_WAIT: begin
          if (guard != '0) begin
            guard <= guard - GUARD_W'(1);
          end else if (mm_done) begin
            acc <= mm_product;
`ifdef CONST_TIME_EN
            state <= ST_MUL_GO;
`else
            state <= cur_bit ? ST_MUL_GO : ST_NEXT;
`endif
          end
        end
        ST_MUL_GO: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= base;
          guard    <= GUARD_W'(MM_GUARD);
          state    <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (guard != '0) begin
            guard <= guard - GUARD_W'(1);
          end else if (mm_done) begin
`ifdef CONST_TIME_EN
            if (cur_bit) acc <= mm_product;
`else
            acc <= mm_product;
`endif
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_bit) begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_FIN;
          end else begin
            state <= ST_SQ_GO;
          end
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_mm_start_pulse: assert property (@(posedge clk) disable iff (reset) mm_start |=> !mm_start);
  a_done_not_busy:  assert property (@(posedge clk) disable iff (reset) done |-> !busy);

endmodule
